// File: rtl/uart_tx_port.sv
// Memory-mapped 8N1 serial transmitter for the 8-bit CPU bus.
// Stores to the data address fill a small FIFO; the status address reports FIFO and line state.
module uart_tx_port #(
    parameter logic [7:0] ADDR_DATA    = 8'hFE,
    parameter logic [7:0] ADDR_STAT    = 8'hFF,
    parameter int         CLKS_PER_BIT = 16,
    parameter int         FIFO_AW      = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       read,
    input  logic       write,
    input  logic [7:0] address,
    input  logic [7:0] data_in,
    output logic [7:0] data_out,
    output logic       sel,
    output logic       ready,
    output logic       tx,
    output logic       busy
);

    localparam int DEPTH = 1 << FIFO_AW;
    localparam int CNTW  = FIFO_AW + 1;
    localparam int CW    = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;

    localparam logic [CW-1:0]      BAUD_TOP  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0]      BAUD_ZERO = {CW{1'b0}};
    localparam logic [CW-1:0]      BAUD_ONE  = CW'(1);
    localparam logic [CNTW-1:0]    CNT_FULL  = CNTW'(DEPTH);
    localparam logic [CNTW-1:0]    CNT_ZERO  = {CNTW{1'b0}};
    localparam logic [FIFO_AW-1:0] PTR_ONE   = FIFO_AW'(1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_START = 2'd1;
    localparam logic [1:0] ST_DATA  = 2'd2;
    localparam logic [1:0] ST_STOP  = 2'd3;

    logic [1:0]         state_r, state_nxt_s;
    logic [CW-1:0]      cnt_r, cnt_nxt_s;
    logic [2:0]         bit_idx_r, bit_idx_nxt_s;
    logic [7:0]         shift_r, shift_nxt_s;
    logic               tx_r, tx_nxt_s;
    logic               busy_r, ready_r, overflow_r;
    logic [7:0]         data_out_r;
    logic [CNTW-1:0]    count_r, count_nxt_s;
    logic [FIFO_AW-1:0] wr_ptr_r, rd_ptr_r;
    logic [7:0]         fifo_mem_r [DEPTH];

    logic       hit_data_s, hit_stat_s, access_s, rd_acc_s;
    logic       full_s, empty_s, push_s, pop_s, ovf_set_s, ovf_clr_s;
    logic [3:0] cnt4_s;
    logic [7:0] status_s;

    assign hit_data_s = (address == ADDR_DATA);
    assign hit_stat_s = (address == ADDR_STAT);
    assign sel        = hit_data_s | hit_stat_s;
    assign access_s   = (read | write) & sel;
    assign rd_acc_s   = read & ~write & sel;
    assign full_s     = (count_r == CNT_FULL);
    assign empty_s    = (count_r == CNT_ZERO);
    assign pop_s      = (state_r == ST_IDLE) & ~empty_s;
    // Fullness is judged before any same-cycle pop, so a push into a full FIFO always drops.
    assign push_s     = write & hit_data_s & ~full_s;
    assign ovf_set_s  = write & hit_data_s & full_s;
    assign ovf_clr_s  = write & hit_stat_s;
    assign cnt4_s     = 4'(count_r);
    assign status_s   = {cnt4_s, overflow_r, (state_r != ST_IDLE), empty_s, full_s};
    assign count_nxt_s = count_r + CNTW'(push_s) - CNTW'(pop_s);

    assign data_out = data_out_r;
    assign ready    = ready_r;
    assign tx       = tx_r;
    assign busy     = busy_r;

    // Next-state logic of the serialiser; tx_nxt_s is the line level for the state being entered.
    always_comb begin
        state_nxt_s   = state_r;
        cnt_nxt_s     = cnt_r;
        bit_idx_nxt_s = bit_idx_r;
        shift_nxt_s   = shift_r;
        tx_nxt_s      = 1'b1;
        case (state_r)
            ST_IDLE: begin
                if (pop_s) begin
                    shift_nxt_s = fifo_mem_r[rd_ptr_r];
                    cnt_nxt_s   = BAUD_TOP;
                    state_nxt_s = ST_START;
                    tx_nxt_s    = 1'b0;
                end else begin
                    cnt_nxt_s   = BAUD_ZERO;
                end
            end
            ST_START: begin
                if (cnt_r == BAUD_ZERO) begin
                    state_nxt_s   = ST_DATA;
                    bit_idx_nxt_s = 3'd0;
                    cnt_nxt_s     = BAUD_TOP;
                    tx_nxt_s      = shift_r[0];
                end else begin
                    cnt_nxt_s = cnt_r - BAUD_ONE;
                    tx_nxt_s  = 1'b0;
                end
            end
            ST_DATA: begin
                if (cnt_r == BAUD_ZERO) begin
                    cnt_nxt_s     = BAUD_TOP;
                    shift_nxt_s   = {1'b0, shift_r[7:1]};
                    bit_idx_nxt_s = bit_idx_r + 3'd1;
                    if (bit_idx_r == 3'd7) begin
                        state_nxt_s = ST_STOP;
                        tx_nxt_s    = 1'b1;
                    end else begin
                        tx_nxt_s    = shift_r[1];
                    end
                end else begin
                    cnt_nxt_s = cnt_r - BAUD_ONE;
                    tx_nxt_s  = shift_r[0];
                end
            end
            ST_STOP: begin
                if (cnt_r == BAUD_ZERO) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    cnt_nxt_s = cnt_r - BAUD_ONE;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
                cnt_nxt_s   = BAUD_ZERO;
            end
        endcase
    end

    // Serialiser, FIFO pointers/count and busy flag.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r   <= ST_IDLE;
            cnt_r     <= BAUD_ZERO;
            bit_idx_r <= 3'd0;
            shift_r   <= 8'h00;
            tx_r      <= 1'b1;
            busy_r    <= 1'b0;
            count_r   <= CNT_ZERO;
            wr_ptr_r  <= {FIFO_AW{1'b0}};
            rd_ptr_r  <= {FIFO_AW{1'b0}};
        end else begin
            state_r   <= state_nxt_s;
            cnt_r     <= cnt_nxt_s;
            bit_idx_r <= bit_idx_nxt_s;
            shift_r   <= shift_nxt_s;
            tx_r      <= tx_nxt_s;
            busy_r    <= (state_nxt_s != ST_IDLE) | (count_nxt_s != CNT_ZERO);
            count_r   <= count_nxt_s;
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
        end
    end

    // FIFO storage.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                fifo_mem_r[i] <= 8'h00;
            end
        end else if (push_s) begin
            fifo_mem_r[wr_ptr_r] <= data_in;
        end
    end

    // Bus acknowledge, read data and sticky overflow flag.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ready_r    <= 1'b0;
            data_out_r <= 8'h00;
            overflow_r <= 1'b0;
        end else begin
            ready_r <= access_s;
            if (rd_acc_s) begin
                data_out_r <= hit_stat_s ? status_s : 8'h00;
            end
            if (ovf_clr_s) begin
                overflow_r <= 1'b0;
            end else if (ovf_set_s) begin
                overflow_r <= 1'b1;
            end
        end
    end

endmodule
